// File: rtl/dmem_arbiter.sv
// dmem_arbiter: arbitrates a single-port 32x32 data memory between the CPU MEM stage and a DMA/debug burst port.
//   clk, clrn                          clock (rising edge), asynchronous active-low reset
//   c_req/c_we/c_addr/c_wdata          CPU single-word request
//   c_ready, c_rdata, c_rvalid         CPU grant (combinational), registered read data and its valid pulse
//   d_req/d_we/d_addr/d_len/d_wdata    DMA burst request (d_len 0 means 1, clamped to MAX_BURST)
//   d_ready, d_rdata, d_rvalid, d_busy DMA beat grant, registered read data, valid pulse, burst in progress
//   ram_we/ram_addr/ram_wdata/ram_rdata memory port (ram_rdata is combinational from ram_addr)
module dmem_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int MAX_BURST    = 8
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic        c_req,
    input  logic        c_we,
    input  logic [4:0]  c_addr,
    input  logic [31:0] c_wdata,
    output logic        c_ready,
    output logic [31:0] c_rdata,
    output logic        c_rvalid,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [4:0]  d_addr,
    input  logic [3:0]  d_len,
    input  logic [31:0] d_wdata,
    output logic        d_ready,
    output logic [31:0] d_rdata,
    output logic        d_rvalid,
    output logic        d_busy,
    output logic        ram_we,
    output logic [4:0]  ram_addr,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    typedef enum logic {IDLE, DMA_BURST} state_t;
    state_t        state_q, state_d;
    logic [SW-1:0] starve_q, starve_d;
    logic [3:0]    beat_q, beat_d, len_q, len_d, new_len;
    logic [4:0]    base_q, base_d;
    logic          dir_q, dir_d;
    logic [31:0]   c_rdata_q, c_rdata_d, d_rdata_q, d_rdata_d;
    logic          c_rvalid_q, c_rvalid_d, d_rvalid_q, d_rvalid_d;
    logic          in_burst, starved, dma_win, cpu_win;
    always_comb begin
        in_burst = state_q == DMA_BURST;
        starved  = starve_q == SW'(STARVE_LIMIT);
        // Grants are gated by clrn so nothing reaches the memory while reset is held.
        dma_win  = clrn && !in_burst && d_req && (!c_req || starved);
        cpu_win  = clrn && !in_burst && c_req && !dma_win;
        new_len  = d_len == 4'd0 ? 4'd1 : d_len > 4'(MAX_BURST) ? 4'(MAX_BURST) : d_len;
        c_ready  = cpu_win;
        d_ready  = in_burst || dma_win;
        ram_addr  = in_burst ? base_q + {1'b0, beat_q} : dma_win ? d_addr : cpu_win ? c_addr : 5'd0;
        ram_we    = in_burst ? dir_q : dma_win ? d_we : cpu_win && c_we;
        ram_wdata = d_ready ? d_wdata : cpu_win ? c_wdata : 32'd0;
        c_rvalid_d = cpu_win && !c_we;
        d_rvalid_d = (in_burst && !dir_q) || (dma_win && !d_we);
        c_rdata_d  = c_rvalid_d ? ram_rdata : c_rdata_q;
        d_rdata_d  = d_rvalid_d ? ram_rdata : d_rdata_q;
        state_d = state_q;
        beat_d  = beat_q;
        base_d  = base_q;
        dir_d   = dir_q;
        len_d   = len_q;
        if (in_burst) begin
            beat_d = beat_q + 4'd1;
            if (beat_q == len_q - 4'd1) begin
                state_d = IDLE;
                beat_d  = 4'd0;
            end
        end else if (dma_win) begin
            base_d = d_addr;
            dir_d  = d_we;
            len_d  = new_len;
            if (new_len > 4'd1) begin
                state_d = DMA_BURST;
                beat_d  = 4'd1;
            end
        end
        starve_d = in_burst ? starve_q : (!d_req || dma_win) ? '0 : starved ? starve_q : starve_q + SW'(1);
    end
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q    <= IDLE;
            starve_q   <= '0;
            beat_q     <= 4'd0;
            len_q      <= 4'd0;
            base_q     <= 5'd0;
            dir_q      <= 1'b0;
            c_rdata_q  <= 32'd0;
            d_rdata_q  <= 32'd0;
            c_rvalid_q <= 1'b0;
            d_rvalid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            starve_q   <= starve_d;
            beat_q     <= beat_d;
            len_q      <= len_d;
            base_q     <= base_d;
            dir_q      <= dir_d;
            c_rdata_q  <= c_rdata_d;
            d_rdata_q  <= d_rdata_d;
            c_rvalid_q <= c_rvalid_d;
            d_rvalid_q <= d_rvalid_d;
        end
    end
    assign c_rdata  = c_rdata_q;
    assign c_rvalid = c_rvalid_q;
    assign d_rdata  = d_rdata_q;
    assign d_rvalid = d_rvalid_q;
    assign d_busy   = state_q == DMA_BURST;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: checks dmem_arbiter against a queue-based behavioural model with directed and random stimulus.
module tb_dmem_arbiter;
    localparam int STARVE = 4;
    localparam int MAXB   = 8;
    logic        clk, clrn;
    logic        c_req, c_we, c_ready, c_rvalid;
    logic [4:0]  c_addr;
    logic [31:0] c_wdata, c_rdata;
    logic        d_req, d_we, d_ready, d_rvalid, d_busy;
    logic [4:0]  d_addr;
    logic [3:0]  d_len;
    logic [31:0] d_wdata, d_rdata;
    logic        ram_we;
    logic [4:0]  ram_addr;
    logic [31:0] ram_wdata, ram_rdata;
    logic [31:0] ram [32];
    logic [31:0] mm [32];
    int          q [$];
    bit          m_dir, m_cv, m_dv;
    int          m_starve;
    logic [31:0] m_cd, m_dd;
    logic        s_c_ready, s_d_ready, s_busy;
    int          total, bad, beats;

    dmem_arbiter #(.STARVE_LIMIT(STARVE), .MAX_BURST(MAXB)) dut (
        .clk(clk), .clrn(clrn),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_ready(c_ready), .c_rdata(c_rdata), .c_rvalid(c_rvalid),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_len(d_len), .d_wdata(d_wdata),
        .d_ready(d_ready), .d_rdata(d_rdata), .d_rvalid(d_rvalid), .d_busy(d_busy),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    assign ram_rdata = ram[ram_addr];
    always @(posedge clk) if (ram_we) ram[ram_addr] <= ram_wdata;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
        end
    endtask

    // One clock cycle: inputs are already driven; check every output against the model, then advance it.
    task automatic cycle();
        int kind, a, len;
        bit we;
        logic [31:0] wd;
        #1;
        if (!clrn) begin
            q.delete();
            m_starve = 0;
            m_cv = 0; m_dv = 0; m_cd = 0; m_dd = 0;
        end
        // kind: 0 no access, 1 CPU, 2 DMA first beat, 3 DMA continuing beat
        kind = !clrn ? 0 : q.size() > 0 ? 3 : (d_req && (!c_req || m_starve == STARVE)) ? 2 : c_req ? 1 : 0;
        a  = kind == 3 ? q[0] : kind == 2 ? int'(d_addr) : kind == 1 ? int'(c_addr) : 0;
        we = kind == 3 ? m_dir : kind == 2 ? d_we : kind == 1 ? c_we : 1'b0;
        wd = kind >= 2 ? d_wdata : kind == 1 ? c_wdata : 32'd0;
        chk("c_ready", {31'd0, c_ready}, {31'd0, kind == 1});
        chk("d_ready", {31'd0, d_ready}, {31'd0, kind >= 2});
        chk("d_busy", {31'd0, d_busy}, {31'd0, clrn && q.size() > 0});
        chk("ram_we", {31'd0, ram_we}, {31'd0, we});
        chk("ram_addr", {27'd0, ram_addr}, a);
        chk("ram_wdata", ram_wdata, wd);
        chk("c_rvalid", {31'd0, c_rvalid}, {31'd0, m_cv});
        chk("c_rdata", c_rdata, m_cd);
        chk("d_rvalid", {31'd0, d_rvalid}, {31'd0, m_dv});
        chk("d_rdata", d_rdata, m_dd);
        s_c_ready = c_ready; s_d_ready = d_ready; s_busy = d_busy;
        @(posedge clk);
        if (clrn) begin
            m_cv = kind == 1 && !we;
            if (m_cv) m_cd = mm[a];
            m_dv = kind >= 2 && !we;
            if (m_dv) m_dd = mm[a];
            if (we) mm[a] = wd;
            if (kind == 3) void'(q.pop_front());
            if (kind == 2) begin
                len = d_len == 0 ? 1 : (int'(d_len) > MAXB ? MAXB : int'(d_len));
                m_dir = d_we;
                for (int i = 1; i < len; i++) q.push_back((int'(d_addr) + i) % 32);
            end
            if (kind != 3) m_starve = (!d_req || kind == 2) ? 0 : (m_starve < STARVE ? m_starve + 1 : STARVE);
        end
        #1;
    endtask

    initial begin
        total = 0; bad = 0;
        for (int i = 0; i < 32; i++) begin
            ram[i] = (i >= 1 && i <= 8) ? i : 0;
            mm[i]  = ram[i];
        end
        clrn = 0; c_req = 1; c_we = 0; c_addr = 5; c_wdata = 32'h1111_1111;
        d_req = 1; d_we = 0; d_addr = 2; d_len = 1; d_wdata = 32'h2222_2222;
        @(posedge clk); #1;
        cycle();
        cycle();
        chk("rst_ram_we", {31'd0, ram_we}, 32'd0);
        chk("rst_busy", {31'd0, d_busy}, 32'd0);
        clrn = 1;
        cycle();
        chk("lit_cpu_first", {31'd0, s_c_ready}, 32'd1);
        chk("lit_c_rvalid", {31'd0, c_rvalid}, 32'd1);
        chk("lit_c_rdata", c_rdata, 32'h0000_0005);
        cycle(); cycle(); cycle();
        cycle();
        chk("lit_starve_d", {31'd0, s_d_ready}, 32'd1);
        chk("lit_starve_c", {31'd0, s_c_ready}, 32'd0);
        chk("lit_d_rvalid", {31'd0, d_rvalid}, 32'd1);
        chk("lit_d_rdata", d_rdata, 32'h0000_0002);
        c_req = 0; d_req = 0;
        cycle();
        d_req = 1; d_we = 1; d_addr = 30; d_len = 3; d_wdata = 32'hAAAA_AAAA;
        cycle();
        d_req = 0; c_req = 1; c_we = 0; c_addr = 1; d_wdata = 32'hBBBB_BBBB;
        cycle();
        chk("lit_burst_busy1", {31'd0, s_busy}, 32'd1);
        chk("lit_burst_stall1", {31'd0, s_c_ready}, 32'd0);
        d_wdata = 32'hCCCC_CCCC;
        cycle();
        chk("lit_burst_busy2", {31'd0, s_busy}, 32'd1);
        chk("lit_burst_stall2", {31'd0, s_c_ready}, 32'd0);
        cycle();
        chk("lit_burst_done", {31'd0, s_busy}, 32'd0);
        chk("lit_cpu_after", {31'd0, s_c_ready}, 32'd1);
        chk("lit_ram30", ram[30], 32'hAAAA_AAAA);
        chk("lit_ram31", ram[31], 32'hBBBB_BBBB);
        chk("lit_ram0", ram[0], 32'hCCCC_CCCC);
        c_req = 0; d_req = 1; d_we = 1; d_addr = 20; d_len = 0; d_wdata = 32'h5555_0000;
        cycle();
        chk("lit_len0_ready", {31'd0, s_d_ready}, 32'd1);
        d_req = 0;
        cycle();
        chk("lit_len0_nobusy", {31'd0, s_busy}, 32'd0);
        chk("lit_ram20", ram[20], 32'h5555_0000);
        d_req = 1; d_we = 0; d_addr = 16; d_len = 15;
        cycle();
        beats = s_d_ready ? 1 : 0;
        d_req = 0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            beats += s_d_ready ? 1 : 0;
        end
        chk("lit_len15_beats", beats, 32'd8);
        d_req = 1; d_we = 1; d_addr = 10; d_len = 6; d_wdata = 32'hD000_0000;
        cycle();
        d_req = 0; d_wdata = 32'hD000_0001;
        cycle();
        clrn = 0; d_wdata = 32'hD000_0002;
        cycle();
        chk("lit_rst_busy", {31'd0, s_busy}, 32'd0);
        clrn = 1;
        cycle(); cycle(); cycle();
        chk("lit_ram11", ram[11], 32'hD000_0001);
        for (int i = 13; i <= 15; i++) chk("lit_abort", ram[i], 32'd0);
        for (int n = 0; n < 3000; n++) begin
            clrn    = $urandom_range(0, 79) != 0;
            c_req   = $urandom_range(0, 3) != 0;
            c_we    = $urandom_range(0, 1) == 1;
            c_addr  = 5'($urandom_range(0, 31));
            c_wdata = $urandom;
            d_req   = $urandom_range(0, 3) == 0;
            d_we    = $urandom_range(0, 1) == 1;
            d_addr  = 5'($urandom_range(0, 31));
            d_len   = 4'($urandom_range(0, 15));
            d_wdata = $urandom;
            cycle();
        end
        clrn = 1; c_req = 0; d_req = 0;
        for (int i = 0; i < 10; i++) cycle();
        for (int i = 0; i < 32; i++) chk("mem_final", ram[i], mm[i]);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
